// File: rtl/mc_pkg.sv
// Shared constants and types for the multi-cycle MIPS controller: state encoding,
// opcode/func values, and the datapath mux / ALU control encodings.
package mc_pkg;

    typedef enum logic [3:0] {
        ST_RST      = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_MEM_WR   = 4'd7,
        ST_WB_MEM   = 4'd8,
        ST_WB_ALU   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JAL      = 4'd11,
        ST_JR       = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_LUI  = 3'b011;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
    localparam logic [1:0] MEMTOREG_MDR    = 2'b01;
    localparam logic [1:0] MEMTOREG_PC     = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // One-hot instruction class produced by the decoder; all zero means illegal.
    typedef struct packed {
        logic addu;
        logic subu;
        logic jr;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic jal;
    } insn_cls_t;

    // Subset of the class that later states still need after DECODE.
    typedef struct packed {
        logic dst_rd;
        logic alu_sub;
        logic alu_lui;
        logic is_load;
    } insn_sel_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle. The master side is the control FSM; the slave
// side is the datapath, which also gets the combined PC enable.
interface multicycle_ctrl_if #(
    parameter int CNT_W   = 32,
    parameter int STATE_W = 4
);
    logic [5:0]         op;
    logic [5:0]         func;
    logic               zero;
    logic               mem_ready;
    logic               mem_req;
    logic               MemWrite;
    logic               IorD;
    logic               IRWrite;
    logic               PCWrite;
    logic               PCWriteCond;
    logic [1:0]         PCSrc;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [2:0]         ALUCtrl;
    logic               ExtOp;
    logic               RegWrite;
    logic [1:0]         RegDst;
    logic [1:0]         MemtoReg;
    logic               illegal_insn;
    logic [CNT_W-1:0]   retired;
    logic [STATE_W-1:0] state;
    logic               pc_en;

    // beq resolves here: the FSM raises PCWriteCond, the ALU flag qualifies it.
    assign pc_en = PCWrite | (PCWriteCond & zero);

    modport master (
        input  op, func, zero, mem_ready,
        output mem_req, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSrc,
               ALUSrcA, ALUSrcB, ALUCtrl, ExtOp, RegWrite, RegDst, MemtoReg,
               illegal_insn, retired, state
    );

    modport slave (
        output op, func, zero, mem_ready,
        input  mem_req, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSrc,
               ALUSrcA, ALUSrcB, ALUCtrl, ExtOp, RegWrite, RegDst, MemtoReg,
               illegal_insn, retired, state, pc_en
    );
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction classifier: op/func to a one-hot class plus an
// illegal flag for anything outside the supported subset.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output insn_cls_t  cls,
    output logic       illegal
);
    logic rtype;

    always_comb begin
        rtype    = (op == OP_RTYPE);
        cls      = '0;
        cls.addu = rtype && (func == FN_ADDU);
        cls.subu = rtype && (func == FN_SUBU);
        cls.jr   = rtype && (func == FN_JR);
        cls.ori  = (op == OP_ORI);
        cls.lui  = (op == OP_LUI);
        cls.lw   = (op == OP_LW);
        cls.sw   = (op == OP_SW);
        cls.beq  = (op == OP_BEQ);
        cls.jal  = (op == OP_JAL);
        illegal  = ~|cls;
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the shared-ALU multi-cycle MIPS datapath, with a
// memory-ready handshake and a retired-instruction counter.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int CNT_W         = 32,
    parameter int STATE_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.master  bus
);
    state_t           state_q, state_d;
    insn_sel_t        sel_q, sel_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;
    logic             ready_eff;
    insn_cls_t        dec_cls;
    logic             dec_illegal;

    mc_decode u_decode (
        .op      (bus.op),
        .func    (bus.func),
        .cls     (dec_cls),
        .illegal (dec_illegal)
    );

    assign ready_eff   = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;
    assign bus.retired = retired_q;
    assign bus.state   = STATE_W'(state_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RST;
            sel_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        sel_d            = sel_q;
        retire           = 1'b0;
        bus.mem_req      = 1'b0;
        bus.MemWrite     = 1'b0;
        bus.IorD         = 1'b0;
        bus.IRWrite      = 1'b0;
        bus.PCWrite      = 1'b0;
        bus.PCWriteCond  = 1'b0;
        bus.PCSrc        = PCSRC_ALU;
        bus.ALUSrcA      = 1'b0;
        bus.ALUSrcB      = SRCB_RT;
        bus.ALUCtrl      = ALU_ADD;
        bus.ExtOp        = 1'b0;
        bus.RegWrite     = 1'b0;
        bus.RegDst       = REGDST_RT;
        bus.MemtoReg     = MEMTOREG_ALUOUT;
        bus.illegal_insn = 1'b0;

        case (state_q)
            ST_RST: state_d = ST_FETCH;
            ST_FETCH: begin
                bus.mem_req = 1'b1;
                bus.ALUSrcB = SRCB_FOUR;
                // IR and PC+4 are committed only in the cycle memory delivers.
                if (ready_eff) begin
                    bus.IRWrite = 1'b1;
                    bus.PCWrite = 1'b1;
                    state_d     = ST_DECODE;
                end
            end
            ST_DECODE: begin
                bus.ALUSrcB       = SRCB_IMM_SH2;
                sel_d.dst_rd      = dec_cls.addu | dec_cls.subu;
                sel_d.alu_sub     = dec_cls.subu;
                sel_d.alu_lui     = dec_cls.lui;
                sel_d.is_load     = dec_cls.lw;
                bus.illegal_insn  = dec_illegal;
                if (dec_cls.addu || dec_cls.subu)    state_d = ST_EXEC_R;
                else if (dec_cls.jr)                 state_d = ST_JR;
                else if (dec_cls.ori || dec_cls.lui) state_d = ST_EXEC_I;
                else if (dec_cls.lw || dec_cls.sw)   state_d = ST_MEM_ADDR;
                else if (dec_cls.beq)                state_d = ST_BRANCH;
                else if (dec_cls.jal)                state_d = ST_JAL;
                else                                 state_d = ST_FETCH;
            end
            ST_EXEC_R: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUCtrl = sel_q.alu_sub ? ALU_SUB : ALU_ADD;
                state_d     = ST_WB_ALU;
            end
            ST_EXEC_I: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = SRCB_IMM;
                bus.ExtOp   = 1'b1;
                bus.ALUCtrl = sel_q.alu_lui ? ALU_LUI : ALU_OR;
                state_d     = ST_WB_ALU;
            end
            ST_MEM_ADDR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = SRCB_IMM;
                state_d     = sel_q.is_load ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                bus.mem_req = 1'b1;
                bus.IorD    = 1'b1;
                if (ready_eff) state_d = ST_WB_MEM;
            end
            ST_MEM_WR: begin
                bus.mem_req  = 1'b1;
                bus.IorD     = 1'b1;
                bus.MemWrite = 1'b1;
                if (ready_eff) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
            end
            ST_WB_MEM: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = MEMTOREG_MDR;
                state_d      = ST_FETCH;
                retire       = 1'b1;
            end
            ST_WB_ALU: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = sel_q.dst_rd ? REGDST_RD : REGDST_RT;
                state_d      = ST_FETCH;
                retire       = 1'b1;
            end
            ST_BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUCtrl     = ALU_SUB;
                bus.PCWriteCond = 1'b1;
                bus.PCSrc       = PCSRC_ALUOUT;
                state_d         = ST_FETCH;
                retire          = 1'b1;
            end
            ST_JAL: begin
                bus.PCWrite  = 1'b1;
                bus.PCSrc    = PCSRC_JUMP;
                bus.RegWrite = 1'b1;
                bus.RegDst   = REGDST_RA;
                bus.MemtoReg = MEMTOREG_PC;
                state_d      = ST_FETCH;
                retire       = 1'b1;
            end
            ST_JR: begin
                bus.PCWrite = 1'b1;
                bus.PCSrc   = PCSRC_RS;
                state_d     = ST_FETCH;
                retire      = 1'b1;
            end
            default: state_d = ST_RST;
        endcase

        retired_d = retire ? (retired_q + CNT_W'(1)) : retired_q;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle MIPS control unit. It replaces the single-cycle combinational decoder with a Moore FSM that sequences fetch, decode, execute, memory and write-back over several clocks. It drives the shared-ALU multi-cycle datapath and handles a parametrised memory-ready handshake. It also counts retired instructions and flags illegal instructions.

Parameters:
MEM_HANDSHAKE, 1, 1 = FETCH/MEM_RD/MEM_WR hold until mem_ready; 0 = mem_ready ignored and treated as 1
CNT_W, 32, width of retired-instruction counter
STATE_W, 4, width of state encoding

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  6  IR[31:26], held stable by datapath after FETCH
func  in  6  IR[5:0]
zero  in  1  ALU zero flag (beq compare)
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access active
MemWrite  out  1  store strobe (valid only with mem_req)
IorD  out  1  0 = PC address, 1 = ALUOut address
IRWrite  out  1  latch IR
PCWrite  out  1  unconditional PC update
PCWriteCond  out  1  PC update if zero
PCSrc  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target, 11 rs
ALUSrcA  out  1  0 PC, 1 rs
ALUSrcB  out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
ALUCtrl  out  3  000 add, 001 sub, 010 or, 011 lui (B<<16)
ExtOp  out  1  1 zero-extend, 0 sign-extend
RegWrite  out  1  GPR write enable
RegDst  out  2  00 rt, 01 rd, 10 $31
MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC (already PC+4)
illegal_insn  out  1  one-cycle pulse on undecodable instruction
retired  out  CNT_W  retired-instruction count
state  out  STATE_W  current state (debug)

Behaviour:
- Supported instructions: addu, subu, jr (op 000000, func 100001/100011/001000); ori 001101; lui 001111; lw 100011; sw 101011; beq 000100; jal 000011.
- States: RST(0), FETCH(1), DECODE(2), EXEC_R(3), EXEC_I(4), MEM_ADDR(5), MEM_RD(6), MEM_WR(7), WB_MEM(8), WB_ALU(9), BRANCH(10), JAL(11), JR(12).
- Reset: asynchronous entry to RST. All outputs are 0 in RST, retired=0, state=0. RST always moves to FETCH on the next edge.
- FETCH: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUCtrl=add. It stays in FETCH while the handshake is pending. On ready: IRWrite=1, PCWrite=1, PCSrc=00, then DECODE. IRWrite and PCWrite assert only in the ready cycle.
- DECODE: ALUSrcA=0, ALUSrcB=11, add (branch target into ALUOut). Next state:
  - R addu/subu -> EXEC_R
  - jr -> JR
  - ori/lui -> EXEC_I
  - lw/sw -> MEM_ADDR
  - beq -> BRANCH
  - jal -> JAL
  - anything else -> FETCH, with illegal_insn=1 for that cycle and retired unchanged.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, add or sub -> WB_ALU (RegDst=01).
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUCtrl or/lui -> WB_ALU (RegDst=00).
- WB_ALU: RegWrite=1, MemtoReg=00 -> FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ExtOp=0, add -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_req=1, IorD=1. Holds until ready, then WB_MEM.
- WB_MEM: RegWrite=1, RegDst=00, MemtoReg=01 -> FETCH.
- MEM_WR: mem_req=1, IorD=1, MemWrite=1. Holds until ready, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCWriteCond=1, PCSrc=01 -> FETCH.
- JAL: PCWrite=1, PCSrc=10, RegWrite=1, RegDst=10, MemtoReg=10 -> FETCH.
- JR: PCWrite=1, PCSrc=11 -> FETCH.
- retired increments by 1 on the edge leaving any final state: WB_ALU, WB_MEM, MEM_WR (when ready), BRANCH, JAL, JR. It wraps modulo 2^CNT_W without saturation.
- Latency in cycles with ready=1: R/I 4, lw 5, sw 4, beq 3, jal 3, jr 3.
- Outputs are pure Moore decode of state, except IRWrite/PCWrite in FETCH and the MEM_WR counter increment, which are gated by ready.
- Reset asserted mid-instruction aborts immediately. No partial write completes after rst_n falls.
- op/func are sampled only in DECODE.

Decomposition:
- Shared package mc_pkg holds: state localparams, opcode/func constants, ALUCtrl codes, PCSrc/RegDst/MemtoReg/ALUSrcB encodings.
- One sub-module, mc_decode: combinational op/func -> instruction class one-hot, plus illegal.
- The FSM and counter stay in multicycle_ctrl.

Test Plan:
- Reset with rst_n=0 mid-MEM_RD: state=0, all outputs 0, retired=0. After release: RST -> FETCH next cycle.
- addu (op 0, func 21h), ready=1: FETCH, DECODE, EXEC_R, WB_ALU. WB shows RegWrite=1, RegDst=01. retired increments to 1 after 4 cycles.
- lw with mem_ready low for 3 cycles in MEM_RD: mem_req=1, IorD=1 held 4 cycles, no RegWrite until WB_MEM. Total 8 cycles.
- beq with zero=1 and zero=0: both cases show PCWriteCond=1, PCSrc=01 in BRANCH. Returns to FETCH after 3 cycles.
- jal then jr: JAL shows PCWrite=1, PCSrc=10, RegDst=10, MemtoReg=10, RegWrite=1. JR shows PCSrc=11, RegWrite=0.
- op=111111: illegal_insn pulses 1 cycle in DECODE, state goes to FETCH, retired unchanged. With MEM_HANDSHAKE=0 and ready held 0, fetch still completes in 1 cycle.
